// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding and the
// fixed access size used for instruction fetches.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_D  = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational grant selector: data wins unless the fetch streak guard says
// fetch has waited long enough.
module mem_arb_prio (
    input  logic if_req,
    input  logic d_req,
    input  logic streak_full,
    output logic grant_d
);

    always_comb begin
        grant_d = d_req && !(if_req && streak_full);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// load/store. Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    arb_state_e state_q;
    logic       streak_full;
    logic       grant_d;

    mem_arb_prio u_prio (
        .if_req      (if_req),
        .d_req       (d_req),
        .streak_full (streak_full),
        .grant_d     (grant_d)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] streak_q;

    assign streak_full = (streak_q == 3'(STARVE_LIMIT));

    // Counts data grants taken while a fetch was left waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= 3'd0;
        end else if (state_q == IDLE) begin
            if (!if_req) begin
                streak_q <= 3'd0;
            end else if (grant_d) begin
                streak_q <= streak_q + 3'd1;
            end else begin
                streak_q <= 3'd0;
            end
        end
    end
`else
    logic unused_limit;

    assign streak_full  = 1'b0;
    assign unused_limit = ^STARVE_LIMIT;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_funct3 <= 3'b000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                        if (grant_d) begin
                            state_q    <= GNT_D;
                            mem_we     <= d_we;
                            mem_funct3 <= d_funct3;
                            mem_addr   <= d_addr;
                            mem_wdata  <= d_wdata;
                        end else begin
                            state_q    <= GNT_IF;
                            mem_we     <= 1'b0;
                            mem_funct3 <= FETCH_FUNCT3;
                            mem_addr   <= if_addr;
                        end
                    end
                end
                GNT_IF, GNT_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state_q <= RESP;
                        if (state_q == GNT_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                // Requests seen here are ignored so a req still high in the
                // ack cycle is never granted twice.
                RESP: begin
                    if_ack  <= 1'b0;
                    d_ack   <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, a behavioural memory
// with programmable wait states, and grant/response queues checked by monitors.
module tb_mem_arbiter;

    localparam logic [31:0] WR_RDATA = 32'h5707E000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = 8'h00;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_funct3 = 3'b000;
    logic [7:0]  d_addr = 8'h00;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        busy;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ack     (if_ack),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_funct3   (d_funct3),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ack      (d_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_funct3 (mem_funct3),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } gnt_t;

    resp_t exp_q[$];
    gnt_t  gnt_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_gnt(input bit we, input logic [2:0] f3, input logic [7:0] addr,
                            input logic [31:0] wdata);
        gnt_t g;
        g.we = we; g.f3 = f3; g.addr = addr; g.wdata = wdata;
        gnt_q.push_back(g);
    endtask

    task automatic push_exp(input bit is_d, input logic [31:0] rdata);
        resp_t r;
        r.is_d = is_d; r.rdata = rdata;
        exp_q.push_back(r);
    endtask

    // Behavioural memory: acks after mem_wait extra cycles, checks each grant.
    logic [31:0] mem_words [256];
    int          mem_wait = 0;
    int          wcnt = 0;
    bit          stray_ack = 1'b0;
    int          req_cycles = 0;
    bit          in_acc = 1'b0;
    logic [7:0]  held_addr;
    logic        held_we;
    int          last_gnt_cyc = 0;
    int          prev_gnt_cyc = 0;
    gnt_t        g_mod;

    always @(negedge clk) begin
        if (mem_req) begin
            req_cycles++;
            if (!in_acc) begin
                in_acc       = 1'b1;
                held_addr    = mem_addr;
                held_we      = mem_we;
                prev_gnt_cyc = last_gnt_cyc;
                last_gnt_cyc = cyc;
                if (gnt_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL grant_unexpected: got addr %h we %b, expected no grant",
                             mem_addr, mem_we);
                end else begin
                    g_mod = gnt_q.pop_front();
                    check("grant_we", 32'(mem_we), 32'(g_mod.we));
                    check("grant_addr", 32'(mem_addr), 32'(g_mod.addr));
                    check("grant_funct3", 32'(mem_funct3), 32'(g_mod.f3));
                    if (g_mod.we) check("grant_wdata", mem_wdata, g_mod.wdata);
                end
            end else begin
                check("mem_addr_stable", 32'(mem_addr), 32'(held_addr));
                check("mem_we_stable", 32'(mem_we), 32'(held_we));
            end
            if (wcnt == mem_wait) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_words[mem_addr] = mem_wdata;
                    mem_rdata = WR_RDATA;
                end else begin
                    mem_rdata = mem_words[mem_addr];
                end
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            in_acc  = 1'b0;
            wcnt    = 0;
            mem_ack = stray_ack;
            if (stray_ack) mem_rdata = 32'hBAD0BAD0;
        end
    end

    // Response monitor.
    resp_t e_mon;
    int    last_if_ack = 0;
    int    last_d_ack = 0;

    always @(negedge clk) begin
        if (if_ack || d_ack) begin
            if (if_ack && d_ack) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dual_ack: got both acks, expected one");
            end
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ack_unexpected: got if_ack %b d_ack %b, expected none",
                         if_ack, d_ack);
            end else begin
                e_mon = exp_q.pop_front();
                check("ack_port", 32'(d_ack), 32'(e_mon.is_d));
                check("ack_rdata", e_mon.is_d ? d_rdata : if_rdata, e_mon.rdata);
            end
            if (if_ack) last_if_ack = cyc;
            else last_d_ack = cyc;
        end
    end

    int if_left = 0;
    int d_left = 0;

    // Holds requests until the requested number of acks, then waits for idle.
    task automatic run(input int max_cycles);
        int n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (if_ack && if_left > 0) begin
                if_left--;
                if (if_left == 0) if_req = 1'b0;
            end
            if (d_ack && d_left > 0) begin
                d_left--;
                if (d_left == 0) d_req = 1'b0;
            end
            if (if_left == 0 && d_left == 0 && !busy) break;
            if (n >= max_cycles) begin
                n_cmp++;
                n_bad++;
                $display("FAIL run_timeout: got %0d acks outstanding after %0d cycles, expected 0",
                         if_left + d_left, n);
                if_req = 1'b0; d_req = 1'b0; if_left = 0; d_left = 0;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_words[8'h10] = 32'h00A00093;
        mem_words[8'h14] = 32'h00000013;
        mem_words[8'h18] = 32'h00208133;
        mem_words[8'h20] = 32'hFFFFFF80;
        mem_words[8'h30] = 32'h00100073;
        mem_words[8'h44] = 32'h12345678;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", 32'({if_ack, d_ack}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Lone fetch, zero-wait
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 8'h10;
        push_gnt(1'b0, 3'b010, 8'h10, 32'h0);
        push_exp(1'b0, 32'h00A00093);
        @(negedge clk);
        check("t1_c0_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("t1_c1_mem_req", 32'(mem_req), 32'd1);
        check("t1_c1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_c2_mem_req", 32'(mem_req), 32'd0);
        check("t1_c2_if_ack", 32'(if_ack), 32'd1);
        if_req = 1'b0;
        @(negedge clk);
        check("t1_c3_if_ack", 32'(if_ack), 32'd0);
        check("t1_c3_busy", 32'(busy), 32'd0);
        check("t1_c3_if_rdata_hold", if_rdata, 32'h00A00093);

        // Simultaneous requests: store wins, fetch follows
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 8'h14;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
        push_gnt(1'b1, 3'b010, 8'h40, 32'hDEADBEEF);
        push_gnt(1'b0, 3'b010, 8'h14, 32'h0);
        push_exp(1'b1, WR_RDATA);
        push_exp(1'b0, 32'h00000013);
        if_left = 1; d_left = 1;
        run(40);
        check("t2_ack_gap", 32'(last_if_ack - last_d_ack), 32'd3);
        check("t2_store_written", mem_words[8'h40], 32'hDEADBEEF);

        // Load with three wait states
        @(posedge clk); #1;
        mem_wait = 3; req_cycles = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20; d_funct3 = 3'b000;
        push_gnt(1'b0, 3'b000, 8'h20, 32'h0);
        push_exp(1'b1, 32'hFFFFFF80);
        d_left = 1;
        run(40);
        check("t3_req_cycles", 32'(req_cycles), 32'd4);
        check("t3_d_rdata_hold", d_rdata, 32'hFFFFFF80);
        mem_wait = 0;

        // Stray mem_ack while idle is ignored
        stray_ack = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_stray_busy", 32'(busy), 32'd0);
        check("t4_stray_mem_req", 32'(mem_req), 32'd0);
        stray_ack = 1'b0;
        @(negedge clk);

        // Reset in the middle of a data access
        @(posedge clk); #1;
        mem_wait = 10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h44; d_funct3 = 3'b010;
        push_gnt(1'b0, 3'b010, 8'h44, 32'h0);
        repeat (2) @(negedge clk);
        check("t5_in_gnt_busy", 32'(busy), 32'd1);
        check("t5_in_gnt_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_post_rst_mem_req", 32'(mem_req), 32'd0);
        check("t5_post_rst_busy", 32'(busy), 32'd0);
        check("t5_post_rst_d_ack", 32'(d_ack), 32'd0);
        check("t5_post_rst_d_rdata", d_rdata, 32'd0);
        mem_wait = 0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 8'h30;
        push_gnt(1'b0, 3'b010, 8'h30, 32'h0);
        push_exp(1'b0, 32'h00100073);
        if_left = 1;
        run(40);

        // Back-to-back data requests, re-asserted in the ack cycle
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h44; d_funct3 = 3'b010;
        push_gnt(1'b0, 3'b010, 8'h44, 32'h0);
        push_gnt(1'b0, 3'b010, 8'h44, 32'h0);
        push_exp(1'b1, 32'h12345678);
        push_exp(1'b1, 32'h12345678);
        d_left = 2;
        run(40);
        check("t6_grant_spacing", 32'(last_gnt_cyc - prev_gnt_cyc), 32'd3);

        // Continuous data traffic with a waiting fetch
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 8'h18;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h44; d_funct3 = 3'b010;
`ifdef MEM_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) begin
            push_gnt(1'b0, 3'b010, 8'h44, 32'h0);
            push_exp(1'b1, 32'h12345678);
        end
        push_gnt(1'b0, 3'b010, 8'h18, 32'h0);
        push_exp(1'b0, 32'h00208133);
        for (int i = 0; i < 16; i++) begin
            push_gnt(1'b0, 3'b010, 8'h44, 32'h0);
            push_exp(1'b1, 32'h12345678);
        end
`else
        for (int i = 0; i < 20; i++) begin
            push_gnt(1'b0, 3'b010, 8'h44, 32'h0);
            push_exp(1'b1, 32'h12345678);
        end
        push_gnt(1'b0, 3'b010, 8'h18, 32'h0);
        push_exp(1'b0, 32'h00208133);
`endif
        if_left = 1; d_left = 20;
        run(200);

        check("end_resp_q_empty", 32'(exp_q.size()), 32'd0);
        check("end_gnt_q_empty", 32'(gnt_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
